// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: boot-time Avalon-MM reader that fetches system ID and timestamp and publishes sticky pass/fail status
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1688346214,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255,
  parameter int          MAX_RETRIES  = 3,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [1:0]  retries,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_ID  = 3'd1;
  localparam logic [2:0] LAT_ID = 3'd2;
  localparam logic [2:0] RD_TS  = 3'd3;
  localparam logic [2:0] LAT_TS = 3'd4;
  localparam logic [2:0] CHECK  = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;
  logic [2:0]  state, state_n;
  logic        auto_pend;
  logic [15:0] stall_cnt;
  logic [1:0]  lat_cnt;
  logic        rd, accept, expire, retry, lat_done, cap_id, cap_ts, launch;
  assign rd       = state == RD_ID || state == RD_TS;
  assign accept   = rd && !avm_waitrequest;
  assign expire   = rd && avm_waitrequest && stall_cnt == 16'(TIMEOUT - 1);
  assign retry    = expire && retries < 2'(MAX_RETRIES);
  assign lat_done = (state == LAT_ID || state == LAT_TS) && lat_cnt == 2'(READ_LATENCY);
  assign cap_id   = (state == RD_ID && accept && READ_LATENCY == 0) || (state == LAT_ID && lat_done);
  assign cap_ts   = (state == RD_TS && accept && READ_LATENCY == 0) || (state == LAT_TS && lat_done);
  assign launch   = state == IDLE && (start || auto_pend);
  // outputs are pure state decodes so the bus strobe never sees waitrequest combinationally
  assign busy        = state != IDLE;
  assign done        = state == FINISH;
  assign avm_read    = rd;
  assign avm_address = state == RD_TS || state == LAT_TS;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = launch ? RD_ID : IDLE;
      RD_ID:   state_n = expire ? (retry ? RD_ID : FINISH) : accept ? (READ_LATENCY == 0 ? RD_TS : LAT_ID) : RD_ID;
      LAT_ID:  state_n = lat_done ? RD_TS : LAT_ID;
      RD_TS:   state_n = expire ? (retry ? RD_ID : FINISH) : accept ? (READ_LATENCY == 0 ? CHECK : LAT_TS) : RD_TS;
      LAT_TS:  state_n = lat_done ? CHECK : LAT_TS;
      CHECK:   state_n = FINISH;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      auto_pend   <= AUTO_START;
      stall_cnt   <= '0;
      lat_cnt     <= '0;
      retries     <= '0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state     <= state_n;
      auto_pend <= 1'b0;
      // a retry re-enters RD_ID from RD_ID, so expiry must also restart the stall count
      stall_cnt <= (state_n != state || expire) ? '0 : stall_cnt + 16'(rd && avm_waitrequest);
      lat_cnt   <= accept ? 2'd1 : lat_cnt + 2'd1;
      if (launch) begin
        retries     <= '0;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (retry) retries <= retries + 2'd1;
      if (expire && !retry) timeout_err <= 1'b1;
      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;
      if (state == CHECK) begin
        id_ok <= id_value == EXPECTED_ID;
        ts_ok <= ts_value == EXPECTED_TS;
      end
    end
  end
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: two DUTs (latency 0 and 2) against a latency-accurate slave and a run-level outcome model
module tb_sysid_check_ctrl;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1688346214;
  localparam logic [31:0] BAD    = 32'hDEADBEEF;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic [1:0]       start = '0, waitreq, rd, addr, busy, done, id_ok, ts_ok, tmo_err;
  logic [1:0][31:0] rdata, id_v, ts_v;
  logic [1:0][1:0]  ret;
  int stall_id[2], stall_ts[2], stuck[2];
  logic [31:0] sid[2], sts[2];
  int wcnt[2], sused[2], dcount[2];
  logic pv[2][4];
  logic [31:0] pd[2][4];
  logic slv_clr = 1'b0;
  int checks = 0, passed = 0;
  sysid_check_ctrl #(.READ_LATENCY(0), .TIMEOUT(8), .MAX_RETRIES(2), .AUTO_START(1'b1)) u0 (
    .clock(clock), .reset(reset), .start(start[0]), .avm_address(addr[0]), .avm_read(rd[0]),
    .avm_readdata(rdata[0]), .avm_waitrequest(waitreq[0]), .busy(busy[0]), .done(done[0]),
    .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout_err(tmo_err[0]), .retries(ret[0]),
    .id_value(id_v[0]), .ts_value(ts_v[0]));
  sysid_check_ctrl #(.READ_LATENCY(2), .TIMEOUT(8), .MAX_RETRIES(2), .AUTO_START(1'b1)) u1 (
    .clock(clock), .reset(reset), .start(start[1]), .avm_address(addr[1]), .avm_read(rd[1]),
    .avm_readdata(rdata[1]), .avm_waitrequest(waitreq[1]), .busy(busy[1]), .done(done[1]),
    .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout_err(tmo_err[1]), .retries(ret[1]),
    .id_value(id_v[1]), .ts_value(ts_v[1]));
  function automatic int lat(int k);
    return k == 1 ? 2 : 0;
  endfunction
  // slave: forced stalls first, then a per-address stall count; data valid only on the exact latency cycle
  always_comb begin
    waitreq = '0;
    rdata   = '0;
    for (int k = 0; k < 2; k++) begin
      waitreq[k] = rd[k] && (sused[k] < stuck[k] || wcnt[k] < (addr[k] ? stall_ts[k] : stall_id[k]));
      if (lat(k) == 0) rdata[k] = (rd[k] && !waitreq[k]) ? (addr[k] ? sts[k] : sid[k]) : BAD;
      else rdata[k] = pv[k][0] ? pd[k][0] : BAD;
    end
  end
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (slv_clr) begin
        wcnt[k]  <= 0;
        sused[k] <= 0;
      end else if (rd[k]) begin
        if (sused[k] < stuck[k]) sused[k] <= sused[k] + 1;
        else if (waitreq[k]) wcnt[k] <= wcnt[k] + 1;
        else wcnt[k] <= 0;
      end
      for (int i = 0; i < 3; i++) begin
        pv[k][i] <= pv[k][i+1];
        pd[k][i] <= pd[k][i+1];
      end
      pv[k][3] <= 1'b0;
      if (lat(k) > 0 && rd[k] && !waitreq[k]) begin
        pv[k][lat(k)-1] <= 1'b1;
        pd[k][lat(k)-1] <= addr[k] ? sts[k] : sid[k];
      end
      if (done[k]) dcount[k] <= dcount[k] + 1;
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cfg(int k, int si, int st, int sk, logic [31:0] iv, logic [31:0] tv);
    stall_id[k] = si;
    stall_ts[k] = st;
    stuck[k]    = sk;
    sid[k]      = iv;
    sts[k]      = tv;
    @(negedge clock) slv_clr = 1'b1;
    @(negedge clock) slv_clr = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy != 2'b00 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("idle_bound", 32'(busy), 0);
  endtask
  task automatic wait_done(int k, output int cyc);
    cyc = 0;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clock);
      #1;
      start[k] = 1'b0;
      if (done[k]) begin
        cyc = n + 1;
        break;
      end
    end
  endtask
  task automatic check_run(string tag, int k, int cyc, int ecyc, logic iok, logic tok, logic tmo,
                           logic [1:0] eret, logic [31:0] eid, logic [31:0] ets);
    chk({tag, "_cycles"}, cyc, ecyc);
    @(posedge clock);
    #1;
    chk({tag, "_done_width"}, 32'(done[k]), 0);
    chk({tag, "_flags"}, {iok ^ id_ok[k], tok ^ ts_ok[k], tmo ^ tmo_err[k]}, 0);
    chk({tag, "_retries"}, 32'(ret[k]), 32'(eret));
    chk({tag, "_id_value"}, id_v[k], eid);
    chk({tag, "_ts_value"}, ts_v[k], ets);
  endtask
  typedef struct {
    int k; bit br; int si; int st; int sk; logic [31:0] iv; logic [31:0] tv;
    int cyc; logic iok; logic tok; logic tmo; logic [1:0] ret; logic [31:0] eid; logic [31:0] ets;
  } vec_t;
  vec_t tbl[9];
  initial begin
    int cyc, d0, k, si, st, sk, r, ecyc, l;
    logic [31:0] iv, tv;
    logic [31:0] mv_id[2], mv_ts[2];
    tbl[0] = '{0, 1'b1, 0, 0, 0,  EXP_ID,  EXP_TS,        5,  1'b1, 1'b1, 1'b0, 2'd0, EXP_ID,  EXP_TS};
    tbl[1] = '{1, 1'b0, 3, 3, 0,  EXP_ID,  EXP_TS,        15, 1'b1, 1'b1, 1'b0, 2'd0, EXP_ID,  EXP_TS};
    tbl[2] = '{0, 1'b0, 0, 0, 0,  EXP_ID,  32'h12345678,  5,  1'b1, 1'b0, 1'b0, 2'd0, EXP_ID,  32'h12345678};
    tbl[3] = '{0, 1'b0, 0, 0, 24, 32'h11,  32'h22,        26, 1'b0, 1'b0, 1'b1, 2'd2, EXP_ID,  32'h12345678};
    tbl[4] = '{0, 1'b0, 0, 0, 8,  EXP_ID,  EXP_TS,        13, 1'b1, 1'b1, 1'b0, 2'd1, EXP_ID,  EXP_TS};
    tbl[5] = '{1, 1'b0, 0, 0, 24, 32'h33,  32'h44,        26, 1'b0, 1'b0, 1'b1, 2'd2, EXP_ID,  EXP_TS};
    tbl[6] = '{1, 1'b0, 0, 0, 0,  32'h5,   EXP_TS,        9,  1'b0, 1'b1, 1'b0, 2'd0, 32'h5,   EXP_TS};
    tbl[7] = '{0, 1'b0, 2, 5, 8,  32'hCAFE, EXP_TS,       20, 1'b0, 1'b1, 1'b0, 2'd1, 32'hCAFE, EXP_TS};
    tbl[8] = '{1, 1'b0, 1, 0, 16, EXP_ID,  32'h7,         26, 1'b1, 1'b0, 1'b0, 2'd2, EXP_ID,  32'h7};
    for (int j = 0; j < 2; j++) begin
      stall_id[j] = 0; stall_ts[j] = 0; stuck[j] = 0; sid[j] = EXP_ID; sts[j] = EXP_TS;
    end
    repeat (3) @(negedge clock);
    chk("reset_ctrl", {busy, done, id_ok, ts_ok, tmo_err, rd, addr, ret}, 0);
    chk("reset_values", id_v[0] | id_v[1] | ts_v[0] | ts_v[1], 0);
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      cfg(tbl[i].k, tbl[i].si, tbl[i].st, tbl[i].sk, tbl[i].iv, tbl[i].tv);
      if (tbl[i].br) begin
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
      end else begin
        @(negedge clock) start[tbl[i].k] = 1'b1;
      end
      wait_done(tbl[i].k, cyc);
      check_run($sformatf("vec%0d", i), tbl[i].k, cyc, tbl[i].cyc, tbl[i].iok, tbl[i].tok,
                tbl[i].tmo, tbl[i].ret, tbl[i].eid, tbl[i].ets);
    end
    // start re-asserted mid-run must not queue a second run
    wait_idle();
    cfg(0, 2, 2, 0, EXP_ID, EXP_TS);
    d0 = dcount[0];
    @(negedge clock) start[0] = 1'b1;
    @(negedge clock) start[0] = 1'b0;
    repeat (3) @(negedge clock);
    start[0] = 1'b1;
    @(negedge clock) start[0] = 1'b0;
    repeat (20) @(negedge clock);
    chk("start_while_busy_done_count", dcount[0] - d0, 1);
    // start held through FINISH relaunches from the very next IDLE cycle
    d0 = dcount[0];
    @(negedge clock) start[0] = 1'b1;
    for (int n = 0; n < 50 && !done[0]; n++) @(negedge clock);
    chk("hold_start_first_done", 32'(done[0]), 1);
    @(negedge clock);
    chk("hold_start_idle_gap", 32'(busy[0]), 0);
    @(negedge clock);
    chk("hold_start_relaunch", 32'(busy[0]), 1);
    start[0] = 1'b0;
    wait_idle();
    chk("hold_start_done_count", dcount[0] - d0, 2);
    // reset during LAT_TS on the latency-2 DUT
    cfg(1, 0, 0, 0, 32'h55, EXP_TS);
    @(negedge clock) start[1] = 1'b1;
    @(posedge clock);
    #1 start[1] = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("in_lat_ts", {busy[1], rd[1], addr[1]}, 3'b101);
    chk("pre_reset_id_captured", id_v[1], 32'h55);
    reset = 1'b1;
    #1;
    chk("async_reset_ctrl", {busy[1], done[1], id_ok[1], ts_ok[1], tmo_err[1], ret[1], rd[1], addr[1]}, 0);
    chk("async_reset_id", id_v[1], 0);
    repeat (3) @(negedge clock);
    chk("late_data_ignored", ts_v[1], 0);
    cfg(0, 0, 0, 0, EXP_ID, EXP_TS);
    cfg(1, 0, 0, 0, EXP_ID, EXP_TS);
    @(negedge clock) reset = 1'b0;
    wait_done(1, cyc);
    check_run("rerun_after_reset", 1, cyc, 9, 1'b1, 1'b1, 1'b0, 2'd0, EXP_ID, EXP_TS);
    // randomized runs against an outcome-level model
    mv_id[0] = EXP_ID; mv_id[1] = EXP_ID; mv_ts[0] = EXP_TS; mv_ts[1] = EXP_TS;
    for (int i = 0; i < 40; i++) begin
      k  = int'($urandom_range(1, 0));
      si = int'($urandom_range(7, 0));
      st = int'($urandom_range(7, 0));
      r  = int'($urandom_range(3, 0));
      sk = 8 * r;
      iv = $urandom_range(1, 0) ? EXP_ID : $urandom;
      tv = $urandom_range(1, 0) ? EXP_TS : $urandom;
      l  = lat(k);
      wait_idle();
      cfg(k, si, st, sk, iv, tv);
      @(negedge clock) start[k] = 1'b1;
      wait_done(k, cyc);
      if (r == 3) begin
        ecyc = 1 + 24 + 1;
        check_run($sformatf("rand%0d", i), k, cyc, ecyc, 1'b0, 1'b0, 1'b1, 2'd2, mv_id[k], mv_ts[k]);
      end else begin
        ecyc = 1 + 8 * r + (si + 1 + l) + (st + 1 + l) + 2;
        mv_id[k] = iv;
        mv_ts[k] = tv;
        check_run($sformatf("rand%0d", i), k, cyc, ecyc, iv == EXP_ID, tv == EXP_TS, 1'b0,
                  2'(r), iv, tv);
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/sysid_check_ctrl.md
# sysid_check_ctrl

Boot-time sequencer for the system-ID Avalon-MM slave. After reset, or on request, it masters two reads from the ID slave: address 0 (system ID) and address 1 (build timestamp). It compares the results against expected constants and publishes sticky pass/fail status to the board-level LEDs and CPU status register. It handles slave waitrequest, a fixed read latency, timeouts, and bounded retries.

## Interface
Parameters:
- EXPECTED_ID, 32'd0, value required at address 0
- EXPECTED_TS, 32'd1688346214, value required at address 1
- READ_LATENCY, 0, slave read latency in cycles after acceptance; legal range 0..3
- TIMEOUT, 255, maximum cycles a read may stall on waitrequest; legal range 1..65535
- MAX_RETRIES, 3, number of full-sequence retries after a timeout; legal range 0..3
- AUTO_START, 1, when 1, a check runs automatically after reset

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  reset; asynchronous, active-high.
- start  in  1  level-sampled request to run a check; honoured only in IDLE.
- avm_address  out  1  slave address; 0 = ID, 1 = timestamp.
- avm_read  out  1  read strobe.
- avm_readdata  in  32  slave read data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when a check completes (pass or fail).
- id_ok  out  1  sticky; last captured ID equalled EXPECTED_ID.
- ts_ok  out  1  sticky; last captured timestamp equalled EXPECTED_TS.
- timeout_err  out  1  sticky; retries were exhausted.
- retries  out  2  retries consumed in the last run.
- id_value  out  32  last captured ID.
- ts_value  out  32  last captured timestamp.

## Operation
States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, FINISH.

- IDLE: go to RD_ID if start=1. Also go to RD_ID on the first cycle after reset when AUTO_START=1.
- On leaving IDLE for a new run:
  - clear retries, id_ok, ts_ok and timeout_err;
  - keep id_value and ts_value until they are overwritten.
- RD_ID:
  - avm_read=1 and avm_address=0.
  - The read is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
  - On acceptance with READ_LATENCY=0, capture avm_readdata into id_value the same cycle and go to RD_TS.
  - On acceptance with READ_LATENCY>0, go to LAT_ID.
- LAT_ID:
  - avm_read=0; a latency counter runs.
  - On the READ_LATENCY-th cycle after acceptance, capture avm_readdata into id_value and go to RD_TS.
- RD_TS and LAT_TS: identical to RD_ID and LAT_ID, with address 1 and ts_value.
- CHECK: register id_ok = (id_value==EXPECTED_ID) and ts_ok = (ts_value==EXPECTED_TS), then go to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Stall counter:
  - Resets on entry to RD_ID/RD_TS and increments each cycle avm_waitrequest=1 in those states.
  - When it reaches TIMEOUT with waitrequest still high:
    - if retries<MAX_RETRIES, increment retries and restart at RD_ID (id_value/ts_value are not cleared);
    - otherwise set timeout_err=1, leave id_ok=ts_ok=0, and go to FINISH, skipping CHECK.
- A mismatch does not trigger a retry.
- start is ignored while busy. Holding start high after FINISH starts another run on the following IDLE cycle.

## Timing
- Reset values: state IDLE, all outputs 0, id_value=ts_value=0.
- Every output is a register or a decode of the state register. avm_read and avm_address must not depend combinationally on avm_waitrequest.
- Cycle count for a zero-stall run with READ_LATENCY=L, from the IDLE cycle that samples start to the done pulse: 1 + 2·(1+L) + 1 + 1 cycles.
  - L=0 gives 5 cycles: IDLE→RD_ID→RD_TS→CHECK→FINISH.
- avm_address is stable whenever avm_read=1. avm_read drops the cycle after acceptance.
- Reset asserted mid-transaction:
  - outputs clear immediately (asynchronously);
  - read data that arrives afterwards is ignored;
  - AUTO_START reruns after reset is released.

## Test plan
- Nominal: READ_LATENCY=0, slave returns 0 and 1688346214, no stalls. Required: done pulses 5 cycles after release of reset; id_ok=1, ts_ok=1, timeout_err=0, retries=0.
- Latency and stalls: READ_LATENCY=2, waitrequest held 3 cycles on each read. Required: data captured exactly 2 cycles after acceptance, both flags 1, done at cycle 1+2·(4+2)+2 = 15.
- Mismatch: timestamp returns 0x12345678. Required: id_ok=1, ts_ok=0, ts_value=0x12345678, no retry, timeout_err=0.
- Timeout: TIMEOUT=8, MAX_RETRIES=2, waitrequest stuck at 1. Required: three attempts of 8 stall cycles each, retries=2, timeout_err=1, done pulses once, id_ok=ts_ok=0.
- Recovery: waitrequest stuck for the first attempt only, then released. Required: retries=1, both flags 1, timeout_err=0.
- Control: a start pulse while busy is ignored (exactly one done pulse). Reset asserted during LAT_TS clears all outputs immediately, and with AUTO_START=1 a fresh nominal run completes afterwards.
